coef_block_assembler: RTL and testbench



---
 rtl/coef_block_assembler_pkg.sv | 22 ++
 rtl/coef_block_assembler_if.sv | 26 ++
 rtl/coef_block_assembler_amp_extend.sv | 25 ++
 rtl/coef_block_assembler.sv | 159 +++++++++++++++
 tb/tb_coef_block_assembler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/coef_block_assembler_pkg.sv
// rtl/coef_block_assembler_pkg.sv - shared constants and types for the coefficient block assembler
package coef_block_assembler_pkg;

    typedef enum logic [1:0] {
        S_DC   = 2'd0,
        S_AC   = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] EOB_RUN  = 4'd0;
    localparam logic [3:0] ZRL_RUN  = 4'd15;
    localparam logic [3:0] SYM_SIZE0 = 4'd0;

    // Zigzag scan position k -> raster index (row*8 + col)
    localparam int ZIGZAG [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/coef_block_assembler_if.sv
// rtl/coef_block_assembler_if.sv - symbol input stream and coefficient block output stream
interface coef_block_assembler_if #(
    parameter int COEF_W = 12,
    parameter int CH     = 3
);
    logic                               sym_valid;
    logic                               sym_ready;
    logic [3:0]                         sym_run;
    logic [3:0]                         sym_size;
    logic [COEF_W-1:0]                  sym_bits;
    logic [7:0][7:0][COEF_W-1:0]        block;
    logic [$clog2(CH+1)-1:0]            ch;
    logic                               mcu_last;
    logic                               valid_out;
    logic                               ready_out;

    modport slave (
        input  sym_valid, sym_run, sym_size, sym_bits, ready_out,
        output sym_ready, block, ch, mcu_last, valid_out
    );

    modport master (
        output sym_valid, sym_run, sym_size, sym_bits, ready_out,
        input  sym_ready, block, ch, mcu_last, valid_out
    );
endinterface

// File: rtl/coef_block_assembler_amp_extend.sv
// rtl/coef_block_assembler_amp_extend.sv - size/raw-bits to two's-complement amplitude
module amp_extend #(
    parameter int COEF_W = 12
) (
    input  logic [3:0]        size_i,
    input  logic [COEF_W-1:0] bits_i,
    output logic [COEF_W-1:0] value_o,
    output logic              illegal_o
);
    logic [COEF_W-1:0] mask;
    logic [COEF_W-1:0] masked;
    logic              msb;

    always_comb begin
        mask      = ~({COEF_W{1'b1}} << size_i);
        masked    = bits_i & mask;
        // Top bit of the field: mask minus its lower half isolates it
        msb       = |(masked & ~(mask >> 1));
        illegal_o = (32'(size_i) >= COEF_W);
        value_o   = msb ? masked : (masked - mask);
        if (illegal_o) begin
            value_o = '0;
        end
    end
endmodule

// File: rtl/coef_block_assembler.sv
// rtl/coef_block_assembler.sv - DC prediction, zigzag placement and 8x8 block emission
module coef_block_assembler
    import coef_block_assembler_pkg::*;
#(
    parameter int CH       = 3,
    parameter int COEF_W   = 12,
    parameter int MAX_SAMP = 4,
    localparam int SW      = $clog2(MAX_SAMP + 1),
    localparam int CHW     = $clog2(CH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    coef_block_assembler_if.slave  bus,
    input  logic [CH-1:0][SW-1:0]  comp_blocks,
    input  logic                   restart,
    output logic                   err
);
    state_e                        state_q, state_d;
    logic [63:0][COEF_W-1:0]       asm_q, asm_d;
    logic [63:0][COEF_W-1:0]       block_q, block_d;
    logic [CH-1:0][COEF_W-1:0]     pred_q, pred_d;
    logic [6:0]                    k_q, k_d;
    logic [CHW-1:0]                comp_q, comp_d, ch_q, ch_d;
    logic [SW-1:0]                 blk_q, blk_d, blocks_n;
    logic                          mcu_last_q, mcu_last_d, valid_q, valid_d, err_q, err_d;

    logic [COEF_W-1:0] amp;
    logic              amp_illegal, acc, out_free, is_eob, is_zrl, ac_ovf;
    logic [6:0]        tgt, k_adv;

    amp_extend #(.COEF_W(COEF_W)) u_amp (
        .size_i   (bus.sym_size),
        .bits_i   (bus.sym_bits),
        .value_o  (amp),
        .illegal_o(amp_illegal)
    );

    always_comb begin : outputs
        bus.sym_ready = !rst && !restart && (state_q == S_DC || state_q == S_AC);
        bus.block     = block_q;
        bus.ch        = ch_q;
        bus.mcu_last  = mcu_last_q;
        bus.valid_out = valid_q;
        err           = err_q;
    end

    always_comb begin : decode
        acc      = bus.sym_valid && bus.sym_ready;
        out_free = !valid_q || bus.ready_out;
        is_eob   = (bus.sym_run == EOB_RUN) && (bus.sym_size == SYM_SIZE0);
        is_zrl   = (bus.sym_run == ZRL_RUN) && (bus.sym_size == SYM_SIZE0);
        tgt      = k_q + {3'b000, bus.sym_run};
        k_adv    = is_zrl ? (k_q + 7'd16) : (tgt + 7'd1);
        // A ZRL that exactly fills the block is legal; one reaching past 63 is not
        ac_ovf   = is_zrl ? (k_adv > 7'd64) : (tgt > 7'd63);
        blocks_n = (comp_blocks[comp_q] == '0) ? SW'(1) : comp_blocks[comp_q];
    end

    always_comb begin : next_state
        state_d = state_q;
        if (restart) begin
            state_d = S_DC;
        end else begin
            case (state_q)
                S_DC:    if (acc) state_d = S_AC;
                S_AC:    if (acc && (is_eob || ac_ovf || k_adv >= 7'd64)) state_d = S_DONE;
                S_DONE:  if (out_free) state_d = S_DC;
                default: state_d = S_DC;
            endcase
        end
    end

    always_comb begin : datapath
        asm_d      = asm_q;
        block_d    = block_q;
        pred_d     = pred_q;
        k_d        = k_q;
        comp_d     = comp_q;
        blk_d      = blk_q;
        ch_d       = ch_q;
        mcu_last_d = mcu_last_q;
        err_d      = 1'b0;
        valid_d    = valid_q && !bus.ready_out;
        if (restart) begin
            pred_d = '0;
            comp_d = '0;
            blk_d  = '0;
            k_d    = '0;
        end else begin
            case (state_q)
                S_DC: if (acc) begin
                    asm_d          = '0;
                    pred_d[comp_q] = pred_q[comp_q] + amp;
                    asm_d[0]       = pred_d[comp_q];
                    k_d            = 7'd1;
                    err_d          = amp_illegal;
                end
                S_AC: if (acc && !is_eob) begin
                    if (ac_ovf) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = amp_illegal;
                        if (!is_zrl) asm_d[6'(ZIGZAG[tgt[5:0]])] = amp;
                        k_d = k_adv;
                    end
                end
                S_DONE: if (out_free) begin
                    block_d    = asm_q;
                    ch_d       = comp_q;
                    valid_d    = 1'b1;
                    mcu_last_d = 1'b0;
                    if ((blk_q + SW'(1)) >= blocks_n) begin
                        blk_d = '0;
                        if (comp_q == CHW'(CH - 1)) begin
                            comp_d     = '0;
                            mcu_last_d = 1'b1;
                        end else begin
                            comp_d = comp_q + CHW'(1);
                        end
                    end else begin
                        blk_d = blk_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) state_q <= S_DC;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin : data_reg
        if (rst) begin
            asm_q      <= '0;
            block_q    <= '0;
            pred_q     <= '0;
            k_q        <= '0;
            comp_q     <= '0;
            blk_q      <= '0;
            ch_q       <= '0;
            mcu_last_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            block_q    <= block_d;
            pred_q     <= pred_d;
            k_q        <= k_d;
            comp_q     <= comp_d;
            blk_q      <= blk_d;
            ch_q       <= ch_d;
            mcu_last_q <= mcu_last_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_coef_block_assembler.sv
// tb/tb_coef_block_assembler.sv - directed self-checking bench for coef_block_assembler
module tb_coef_block_assembler;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0][2:0] cb = {3'd1, 3'd1, 3'd1};
    logic            restart = 1'b0;
    logic            err;
    int              checks = 0;
    int              errors = 0;
    logic [63:0][11:0] exp_f;

    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    coef_block_assembler_if #(.COEF_W(12), .CH(3)) bus ();

    coef_block_assembler #(.CH(3), .COEF_W(12), .MAX_SAMP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .comp_blocks(cb),
        .restart    (restart),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [3:0] r, input logic [3:0] s, input logic [11:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.sym_valid = 1'b1;
        bus.sym_run   = r;
        bus.sym_size  = s;
        bus.sym_bits  = b;
        while (!bus.sym_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.sym_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout sym_ready=%0b required 1", bus.sym_ready);
        end
        @(posedge clk);
        #1 bus.sym_valid = 1'b0;
    endtask

    task automatic wait_block;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.valid_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.valid_out) begin
            checks++; errors++;
            $display("FAIL block_timeout valid_out=%0b required 1", bus.valid_out);
        end
    endtask

    task automatic pulse_restart;
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b need 0", bus.valid_out); end
        checks++; if (bus.sym_ready !== 1'b0) begin errors++; $display("FAIL rst_sym_ready got %0b need 0", bus.sym_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b need 0", err); end
        checks++; if (bus.block !== '0) begin errors++; $display("FAIL rst_block got %h need 0", bus.block); end
        checks++; if (bus.ch !== 2'd0 || bus.mcu_last !== 1'b0) begin errors++; $display("FAIL rst_ch got ch=%0d last=%0b need 0 0", bus.ch, bus.mcu_last); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.sym_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b need 1", bus.sym_ready); end
    endtask

    task automatic test_sign_dc;
        send(4'd0, 4'd3, 12'b101);
        send(4'd0, 4'd0, 12'd0);
        wait_block;
        exp_f = '0; exp_f[0] = 12'd5;
        checks++; if (bus.block !== exp_f) begin errors++; $display("FAIL sign_dc_block got %h need %h", bus.block, exp_f); end
        checks++; if (bus.ch !== 2'd0 || bus.mcu_last !== 1'b0) begin errors++; $display("FAIL sign_dc_tag got ch=%0d last=%0b need 0 0", bus.ch, bus.mcu_last); end
    endtask

    task automatic test_dc_pred;
        cb = {3'd1, 3'd1, 3'd2};
        pulse_restart;
        send(4'd0, 4'd3, 12'b101); send(4'd0, 4'd0, 12'd0); wait_block;
        checks++; if (bus.block[0][0] !== 12'd5 || bus.ch !== 2'd0) begin errors++; $display("FAIL pred_y0 got %0d ch=%0d need 5 ch=0", bus.block[0][0], bus.ch); end
        send(4'd0, 4'd2, 12'b01); send(4'd0, 4'd0, 12'd0); wait_block;
        checks++; if (bus.block[0][0] !== 12'd3 || bus.ch !== 2'd0 || bus.mcu_last !== 1'b0) begin errors++; $display("FAIL pred_y1 got %0d ch=%0d last=%0b need 3 ch=0 last=0", bus.block[0][0], bus.ch, bus.mcu_last); end
        send(4'd0, 4'd1, 12'b1); send(4'd0, 4'd0, 12'd0); wait_block;
        checks++; if (bus.block[0][0] !== 12'd1 || bus.ch !== 2'd1 || bus.mcu_last !== 1'b0) begin errors++; $display("FAIL pred_cb got %0d ch=%0d last=%0b need 1 ch=1 last=0", bus.block[0][0], bus.ch, bus.mcu_last); end
        send(4'd0, 4'd0, 12'd0); send(4'd0, 4'd0, 12'd0); wait_block;
        checks++; if (bus.ch !== 2'd2 || bus.mcu_last !== 1'b1) begin errors++; $display("FAIL pred_cr got ch=%0d last=%0b need ch=2 last=1", bus.ch, bus.mcu_last); end
    endtask

    task automatic test_zigzag;
        pulse_restart;
        send(4'd0, 4'd0, 12'd0);
        send(4'd1, 4'd1, 12'b1);
        send(4'd15, 4'd0, 12'd0);
        send(4'd0, 4'd2, 12'b00);
        send(4'd0, 4'd0, 12'd0);
        wait_block;
        exp_f = '0; exp_f[8] = 12'd1; exp_f[33] = 12'hFFD;
        checks++; if (bus.block[1][0] !== 12'd1 || bus.block[4][1] !== 12'hFFD) begin errors++; $display("FAIL zz_points got [1][0]=%h [4][1]=%h need 001 ffd", bus.block[1][0], bus.block[4][1]); end
        checks++; if (bus.block !== exp_f) begin errors++; $display("FAIL zz_block got %h need %h", bus.block, exp_f); end
    endtask

    task automatic test_full_block;
        pulse_restart;
        send(4'd0, 4'd0, 12'd0);
        for (int i = 0; i < 63; i++) send(4'd0, 4'd1, 12'b1);
        wait_block;
        exp_f = '0;
        for (int i = 1; i < 64; i++) exp_f[i] = 12'd1;
        checks++; if (bus.block[7][7] !== 12'd1) begin errors++; $display("FAIL full_77 got %h need 001", bus.block[7][7]); end
        checks++; if (bus.block !== exp_f) begin errors++; $display("FAIL full_block got %h need %h", bus.block, exp_f); end
    endtask

    task automatic test_back_to_back;
        logic stable;
        logic rdy_seen;
        stable = 1'b1;
        rdy_seen = 1'b0;
        pulse_restart;
        bus.ready_out = 1'b0;
        send(4'd0, 4'd3, 12'b101); send(4'd0, 4'd0, 12'd0); wait_block;
        send(4'd0, 4'd1, 12'b1); send(4'd0, 4'd0, 12'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b1 || bus.block[0][0] !== 12'd5 || bus.ch !== 2'd0) stable = 1'b0;
            if (bus.sym_ready !== 1'b0) rdy_seen = 1'b1;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold got stable=%0b need 1", stable); end
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL bp_sym_ready got ready_seen=%0b need 0", rdy_seen); end
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.valid_out !== 1'b1 || bus.block[0][0] !== 12'd6) begin errors++; $display("FAIL bp_second got valid=%0b dc=%0d need 1 6", bus.valid_out, bus.block[0][0]); end
        @(posedge clk); #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL bp_drain got valid=%0b need 0", bus.valid_out); end
    endtask

    task automatic test_restart;
        cb = {3'd1, 3'd1, 3'd1};
        pulse_restart;
        send(4'd0, 4'd1, 12'b1); send(4'd0, 4'd0, 12'd0); wait_block;
        send(4'd0, 4'd1, 12'b1);
        @(negedge clk);
        restart = 1'b1;
        bus.sym_valid = 1'b1; bus.sym_run = 4'd0; bus.sym_size = 4'd1; bus.sym_bits = 12'b1;
        #1;
        checks++; if (bus.sym_ready !== 1'b0) begin errors++; $display("FAIL rs_ready got %0b need 0", bus.sym_ready); end
        @(posedge clk);
        #1 restart = 1'b0; bus.sym_valid = 1'b0;
        send(4'd0, 4'd1, 12'b1); send(4'd0, 4'd0, 12'd0); wait_block;
        exp_f = '0; exp_f[0] = 12'd1;
        checks++; if (bus.ch !== 2'd0) begin errors++; $display("FAIL rs_ch got %0d need 0", bus.ch); end
        checks++; if (bus.block !== exp_f) begin errors++; $display("FAIL rs_block got %h need %h", bus.block, exp_f); end
    endtask

    task automatic test_overflow;
        pulse_restart;
        send(4'd0, 4'd0, 12'd0);
        for (int i = 0; i < 59; i++) send(4'd0, 4'd1, 12'b1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_pre_err got %0b need 0", err); end
        send(4'd15, 4'd1, 12'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %0b need 1", err); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0 || bus.valid_out !== 1'b1) begin errors++; $display("FAIL ovf_emit got err=%0b valid=%0b need 0 1", err, bus.valid_out); end
        exp_f = '0;
        for (int i = 1; i < 60; i++) exp_f[zz[i]] = 12'd1;
        checks++; if (bus.block !== exp_f) begin errors++; $display("FAIL ovf_block got %h need %h", bus.block, exp_f); end
    endtask

    initial begin
        bus.sym_valid = 1'b0;
        bus.sym_run   = 4'd0;
        bus.sym_size  = 4'd0;
        bus.sym_bits  = 12'd0;
        bus.ready_out = 1'b1;
        test_reset;
        test_sign_dc;
        test_dc_pred;
        test_zigzag;
        test_full_block;
        test_back_to_back;
        test_restart;
        test_overflow;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
